// File: rtl/priority_encoder_parameterized.sv
// Parameterized priority encoder: picks the lowest (or highest) set request bit.
// Define PRIORITY_ENCODER_REG_OUT_EN to register the outputs (1-cycle latency).
module priority_encoder_parameterized #(
    parameter  int WIDTH        = 8,
    parameter  int MSB_PRIORITY = 0,
    localparam int RW           = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [RW-1:0]    result,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    if ((WIDTH < 2) || (WIDTH > 256)) begin : g_bad_width
        $fatal(1, "priority_encoder_parameterized: WIDTH must be in 2..256");
    end

    // Scan order decides the winner: the last set bit visited overwrites earlier ones.
    function automatic logic [RW-1:0] f_select(input logic [WIDTH-1:0] req);
        logic [RW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_PRIORITY != 0) begin
                idx = req[i] ? RW'(i) : idx;
            end else begin
                idx = req[WIDTH-1-i] ? RW'(WIDTH-1-i) : idx;
            end
        end
        return idx;
    endfunction

    logic [RW-1:0]    w_result;
    logic             w_valid;
    logic [WIDTH-1:0] w_onehot;

    // Combinational priority select shared by both output modes.
    always_comb begin
        w_result = '0;
        w_valid  = 1'b0;
        w_onehot = '0;
        w_valid  = |in;
        if (w_valid) begin
            w_result = f_select(in);
            w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << w_result;
        end else begin
            w_result = '0;
            w_onehot = '0;
        end
    end

`ifdef PRIORITY_ENCODER_REG_OUT_EN
    logic [RW-1:0]    r_result;
    logic             r_valid;
    logic [WIDTH-1:0] r_onehot;

    // Output register; reset wins over any input sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_onehot <= '0;
        end else begin
            r_result <= w_result;
            r_valid  <= w_valid;
            r_onehot <= w_onehot;
        end
    end

    assign result = r_result;
    assign valid  = r_valid;
    assign onehot = r_onehot;
`else
    // clk and rst stay on the port list so both builds share one footprint.
    logic w_unused;
    assign w_unused = clk ^ rst;

    assign result = w_result;
    assign valid  = w_valid;
    assign onehot = w_onehot;
`endif

endmodule

// File: tb/tb_priority_encoder_parameterized.sv
// Scoreboard bench for priority_encoder_parameterized (8-bit LSB/MSB and 5-bit instances).
// Follows PRIORITY_ENCODER_REG_OUT_EN for reset expectations and pre-edge hold checks.
module tb_priority_encoder_parameterized;

    typedef struct {
        logic [2:0] res_l;
        logic [7:0] oh_l;
        logic [2:0] res_m;
        logic [7:0] oh_m;
        logic       v8;
        logic [2:0] res_5;
        logic [4:0] oh_5;
        logic       v5;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in8;
    logic [4:0] in5;

    logic [2:0] res_l, res_m, res_5;
    logic       val_l, val_m, val_5;
    logic [7:0] oh_l, oh_m;
    logic [4:0] oh_5;

    exp_t sb_q[$];
    exp_t prev_e;
    exp_t mon_e;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    priority_encoder_parameterized #(.WIDTH(8), .MSB_PRIORITY(0)) u_lsb (
        .clk(clk), .rst(rst), .in(in8), .result(res_l), .valid(val_l), .onehot(oh_l)
    );
    priority_encoder_parameterized #(.WIDTH(8), .MSB_PRIORITY(1)) u_msb (
        .clk(clk), .rst(rst), .in(in8), .result(res_m), .valid(val_m), .onehot(oh_m)
    );
    priority_encoder_parameterized #(.WIDTH(5), .MSB_PRIORITY(0)) u_w5 (
        .clk(clk), .rst(rst), .in(in5), .result(res_5), .valid(val_5), .onehot(oh_5)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [7:0] i8, input logic [4:0] i5,
                         input logic [2:0] rl, input logic [7:0] ohl,
                         input logic [2:0] rm, input logic [7:0] ohm, input logic v8,
                         input logic [2:0] r5, input logic [4:0] oh5, input logic v5);
        exp_t e;
        e.res_l = rl; e.oh_l = ohl; e.res_m = rm; e.oh_m = ohm; e.v8 = v8;
        e.res_5 = r5; e.oh_5 = oh5; e.v5 = v5;
        @(negedge clk);
        rst = r;
        in8 = i8;
        in5 = i5;
        sb_q.push_back(e);
`ifdef PRIORITY_ENCODER_REG_OUT_EN
        #1;
        check("hold_result", {5'd0, res_l}, {5'd0, prev_e.res_l});
        check("hold_valid", {7'd0, val_l}, {7'd0, prev_e.v8});
`endif
        prev_e = e;
    endtask

    // Monitor: every output sample after a rising edge consumes one expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("lsb_result", {5'd0, res_l}, {5'd0, mon_e.res_l});
                check("lsb_valid",  {7'd0, val_l}, {7'd0, mon_e.v8});
                check("lsb_onehot", oh_l, mon_e.oh_l);
                check("msb_result", {5'd0, res_m}, {5'd0, mon_e.res_m});
                check("msb_valid",  {7'd0, val_m}, {7'd0, mon_e.v8});
                check("msb_onehot", oh_m, mon_e.oh_m);
                check("w5_result",  {5'd0, res_5}, {5'd0, mon_e.res_5});
                check("w5_valid",   {7'd0, val_5}, {7'd0, mon_e.v5});
                check("w5_onehot",  {3'd0, oh_5}, {3'd0, mon_e.oh_5});
            end
        end
    end

    initial begin
        rst = 1'b1;
        in8 = 8'h00;
        in5 = 5'b00000;
        prev_e = '{3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 5'h00, 1'b0};
        repeat (2) @(posedge clk);

        //    rst   in8    in5        res_l oh_l   res_m oh_m   v8    res_5 oh_5   v5
        apply(1'b1, 8'h00, 5'b00000,  3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 5'h00, 1'b0);
        apply(1'b0, 8'h00, 5'b00000,  3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 5'h00, 1'b0);
        apply(1'b0, 8'hA4, 5'b00001,  3'd2, 8'h04, 3'd7, 8'h80, 1'b1, 3'd0, 5'h01, 1'b1);
        apply(1'b0, 8'hFF, 5'b00010,  3'd0, 8'h01, 3'd7, 8'h80, 1'b1, 3'd1, 5'h02, 1'b1);
        apply(1'b0, 8'h26, 5'b00100,  3'd1, 8'h02, 3'd5, 8'h20, 1'b1, 3'd2, 5'h04, 1'b1);
        apply(1'b0, 8'h80, 5'b01000,  3'd7, 8'h80, 3'd7, 8'h80, 1'b1, 3'd3, 5'h08, 1'b1);
        apply(1'b0, 8'h40, 5'b10000,  3'd6, 8'h40, 3'd6, 8'h40, 1'b1, 3'd4, 5'h10, 1'b1);
        apply(1'b0, 8'h01, 5'b11111,  3'd0, 8'h01, 3'd0, 8'h01, 1'b1, 3'd0, 5'h01, 1'b1);
        apply(1'b0, 8'h18, 5'b11000,  3'd3, 8'h08, 3'd4, 8'h10, 1'b1, 3'd3, 5'h08, 1'b1);
        apply(1'b0, 8'h81, 5'b10100,  3'd0, 8'h01, 3'd7, 8'h80, 1'b1, 3'd2, 5'h04, 1'b1);
        apply(1'b0, 8'h7E, 5'b00000,  3'd1, 8'h02, 3'd6, 8'h40, 1'b1, 3'd0, 5'h00, 1'b0);
`ifdef PRIORITY_ENCODER_REG_OUT_EN
        apply(1'b1, 8'h40, 5'b10000,  3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 5'h00, 1'b0);
`else
        apply(1'b1, 8'h40, 5'b10000,  3'd6, 8'h40, 3'd6, 8'h40, 1'b1, 3'd4, 5'h10, 1'b1);
`endif
        apply(1'b0, 8'h40, 5'b10000,  3'd6, 8'h40, 3'd6, 8'h40, 1'b1, 3'd4, 5'h10, 1'b1);

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
